// File: rtl/segapad_responder.sv
// Sega Genesis 3/6-button pad responder for a SERJOYSTICK-style user port.
// Tracks TH falling edges to step through the 6-button read sequence.
module segapad_responder #(
    parameter int TIMEOUT_CYCLES = 75000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] joy,
    input  logic        six_btn,
    input  logic        th_in,
    output logic [5:0]  pad_out,
    output logic [2:0]  phase
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TEXP = TW'(TIMEOUT_CYCLES - 1);

    logic          r_th_s1;
    logic          r_th_s2;
    logic          r_th_prev;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_phase;
    logic [5:0]    r_pad;

    logic       w_fall;
    logic       w_rise;
    logic       w_edge;
    logic       w_tend;
    logic       w_six3;
    logic       w_six4;
    logic [5:0] w_pad_nxt;

    assign w_fall = r_th_prev & ~r_th_s2;
    assign w_rise = ~r_th_prev & r_th_s2;
    assign w_edge = w_fall | w_rise;
    assign w_tend = (r_timer == TEXP);
    assign w_six3 = six_btn && (r_phase == 3'd3);
    assign w_six4 = six_btn && (r_phase == 3'd4);

    // Output follows the edge-detect flop so level and phase change together.
    always_comb begin
        w_pad_nxt = 6'b111111;
        if (r_th_prev) begin
            if (w_six3)
                w_pad_nxt = ~{joy[6], joy[5], joy[8], joy[9], joy[10], joy[11]};
            else
                w_pad_nxt = ~{joy[6], joy[5], joy[0], joy[1], joy[2], joy[3]};
        end else begin
            if (w_six3)
                w_pad_nxt = {~joy[7], ~joy[4], 4'b0000};
            else if (w_six4)
                w_pad_nxt = {~joy[7], ~joy[4], 4'b1111};
            else
                w_pad_nxt = {~joy[7], ~joy[4], 2'b00, ~joy[2], ~joy[3]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_th_s1   <= 1'b1;
            r_th_s2   <= 1'b1;
            r_th_prev <= 1'b1;
            r_timer   <= '0;
            r_phase   <= 3'd0;
            r_pad     <= 6'b111111;
        end else begin
            r_th_s1   <= th_in;
            r_th_s2   <= r_th_s1;
            r_th_prev <= r_th_s2;
            r_pad     <= w_pad_nxt;

            if (w_edge)
                r_timer <= '0;
            else if (r_timer != TMAX)
                r_timer <= r_timer + 1'b1;

            // A falling edge on the expiry cycle starts a fresh sequence.
            if (w_fall) begin
                if (w_tend)
                    r_phase <= 3'd1;
                else if (r_phase != 3'd5)
                    r_phase <= r_phase + 3'd1;
            end else if (w_tend && !w_rise) begin
                r_phase <= 3'd0;
            end
        end
    end

    assign pad_out = r_pad;
    assign phase   = r_phase;

endmodule

// File: tb/tb_segapad_responder.sv
// Directed-vector bench for segapad_responder with a short timeout.
// Covers 3/6-button sequences, timeout, reset and jittered TH.
`timescale 1ns/1ps
module tb_segapad_responder;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] joy;
    logic        six_btn;
    logic        th_in;
    logic [5:0]  pad_out;
    logic [2:0]  phase;

    int n_cmp = 0;
    int n_bad = 0;

    segapad_responder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .joy     (joy),
        .six_btn (six_btn),
        .th_in   (th_in),
        .pad_out (pad_out),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] joy;
        logic        six;
        logic        th;
        int          hold;
        logic [5:0]  pad;
        logic [2:0]  ph;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic [11:0] j, input logic s, input logic t,
                       input int h, input logic [5:0] p, input logic [2:0] f);
        vec_t v;
        v.joy = j; v.six = s; v.th = t; v.hold = h; v.pad = p; v.ph = f;
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fall_rise();
        th_in = 1'b0;
        cyc(6);
        th_in = 1'b1;
        cyc(6);
    endtask

    task automatic idle();
        th_in = 1'b1;
        cyc(TO + 10);
    endtask

    int nf;

    initial begin
        reset_n = 1'b0;
        joy     = 12'h000;
        six_btn = 1'b0;
        th_in   = 1'b1;
        cyc(2);
        chk("rst_pad", {2'b0, pad_out}, 8'h3f);
        chk("rst_phase", {5'b0, phase}, 8'd0);
        reset_n = 1'b1;
        cyc(2);
        chk("post_rst_pad", {2'b0, pad_out}, 8'h3f);

        // 3-button protocol: ID pattern must never appear
        add(12'h048, 0, 1, 6, 6'b011110, 0);
        add(12'h0A5, 0, 1, 6, 6'b100101, 0);
        add(12'h990, 0, 0, 6, 6'b000011, 1);
        add(12'h990, 0, 1, 6, 6'b111111, 1);
        add(12'h990, 0, 0, 6, 6'b000011, 2);
        add(12'h990, 0, 1, 6, 6'b111111, 2);
        add(12'h990, 0, 0, 6, 6'b000011, 3);
        add(12'h990, 0, 1, 6, 6'b111111, 3);
        add(12'h990, 0, 0, 6, 6'b000011, 4);
        add(12'h990, 0, 1, 6, 6'b111111, 4);
        add(12'h990, 0, 0, 6, 6'b000011, 5);
        add(12'h990, 0, 1, 6, 6'b111111, 5);
        add(12'h0A5, 0, 0, 6, 6'b010001, 5);
        add(12'h0A5, 0, 1, TO + 10, 6'b100101, 0);
        // 6-button protocol
        add(12'h900, 1, 1, 6, 6'b111111, 0);
        add(12'h900, 1, 0, 6, 6'b110011, 1);
        add(12'h900, 1, 1, 6, 6'b111111, 1);
        add(12'h900, 1, 0, 6, 6'b110011, 2);
        add(12'h900, 1, 1, 6, 6'b111111, 2);
        add(12'h900, 1, 0, 6, 6'b110000, 3);
        add(12'h900, 1, 1, 6, 6'b110110, 3);
        add(12'h900, 1, 0, 6, 6'b111111, 4);
        add(12'h900, 1, 1, 6, 6'b111111, 4);
        add(12'h900, 1, 0, 6, 6'b110011, 5);
        add(12'h900, 1, 1, 6, 6'b111111, 5);
        add(12'h990, 1, 0, 6, 6'b000011, 5);
        add(12'h990, 1, 1, TO + 10, 6'b111111, 0);
        add(12'h900, 1, 0, 6, 6'b110011, 1);

        foreach (tv[i]) begin
            joy     = tv[i].joy;
            six_btn = tv[i].six;
            th_in   = tv[i].th;
            cyc(tv[i].hold);
            chk($sformatf("vec%0d_pad", i), {2'b0, pad_out}, {2'b0, tv[i].pad});
            chk($sformatf("vec%0d_phase", i), {5'b0, phase}, {5'b0, tv[i].ph});
        end

        // TH-to-pad latency is exactly 4 edges
        six_btn = 1'b0;
        joy = 12'h090;
        idle();
        chk("lat_pre", {2'b0, pad_out}, 8'h3f);
        th_in = 1'b0;
        cyc(3);
        chk("lat_3", {2'b0, pad_out}, 8'h3f);
        cyc(1);
        chk("lat_4", {2'b0, pad_out}, 8'b00000011);
        chk("lat_phase", {5'b0, phase}, 8'd1);

        // six_btn switch mid-sequence and 1-cycle joy latency
        idle();
        six_btn = 1'b1;
        joy = 12'h900;
        fall_rise();
        fall_rise();
        fall_rise();
        chk("sw_pre", {2'b0, pad_out}, 8'b00110110);
        six_btn = 1'b0;
        cyc(1);
        chk("sw_off", {2'b0, pad_out}, 8'h3f);
        chk("sw_phase", {5'b0, phase}, 8'd3);
        six_btn = 1'b1;
        cyc(1);
        chk("sw_on", {2'b0, pad_out}, 8'b00110110);
        joy = 12'h000;
        cyc(1);
        chk("joy_lat", {2'b0, pad_out}, 8'h3f);

        // falling edge one cycle before expiry counts normally
        joy = 12'h900;
        idle();
        fall_rise();
        fall_rise();
        th_in = 1'b0;
        cyc(6);
        th_in = 1'b1;
        cyc(TO - 1);
        th_in = 1'b0;
        cyc(5);
        chk("pre_exp_phase", {5'b0, phase}, 8'd4);
        chk("pre_exp_pad", {2'b0, pad_out}, 8'h3f);

        // falling edge exactly on the expiry cycle restarts at 1
        idle();
        chk("idle_phase", {5'b0, phase}, 8'd0);
        fall_rise();
        fall_rise();
        th_in = 1'b0;
        cyc(6);
        th_in = 1'b1;
        cyc(TO);
        th_in = 1'b0;
        cyc(5);
        chk("on_exp_phase", {5'b0, phase}, 8'd1);
        chk("on_exp_pad", {2'b0, pad_out}, 8'b00110011);

        // asynchronous reset mid-sequence
        idle();
        fall_rise();
        fall_rise();
        fall_rise();
        chk("mid_pre", {5'b0, phase}, 8'd3);
        #2 reset_n = 1'b0;
        #1;
        chk("async_pad", {2'b0, pad_out}, 8'h3f);
        chk("async_phase", {5'b0, phase}, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(2);
        chk("rel_pad", {2'b0, pad_out}, 8'h3f);
        th_in = 1'b0;
        cyc(5);
        chk("restart_phase", {5'b0, phase}, 8'd1);
        chk("restart_pad", {2'b0, pad_out}, 8'b00110011);
        th_in = 1'b1;

        // jittered TH against a simple edge counter
        idle();
        nf = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #($urandom_range(1, 9));
            th_in = 1'b0;
            nf++;
            cyc(5);
            chk("jit_phase", {5'b0, phase}, (nf > 5) ? 8'd5 : 8'(nf));
            @(posedge clk);
            #($urandom_range(1, 9));
            th_in = 1'b1;
            cyc(4);
            if (i % 7 == 6) begin
                idle();
                nf = 0;
                chk("jit_idle", {5'b0, phase}, 8'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
